// File: rtl/ln_x_scaler.sv
`default_nettype none
// ============================================================================
// Module   : ln_x_scaler
// Brief    : One-step range reduction of x into [0.75, 1.5) for ln(x),
//            tracking shift count k and correction term k*ln2.
// Revision : 1.0 - initial release
// ============================================================================
module ln_x_scaler #(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 16,
  parameter int SHIFT_W = 6,
  parameter int LN2     = 45426
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                clear_i,
  input  logic [DATA_W-1:0]   x_i,
  output logic [DATA_W-1:0]   x_o,
  output logic                done_o,
  output logic                err_o,
  output logic                busy_o,
  output logic [SHIFT_W-1:0]  shift_cnt_o,
  output logic [DATA_W-1:0]   corr_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [DATA_W-1:0]  c_hi    = DATA_W'(3) << (FRAC_W - 1);
  localparam logic [DATA_W-1:0]  c_lo    = DATA_W'(3) << (FRAC_W - 2);
  localparam logic [DATA_W-1:0]  c_ln2   = DATA_W'(LN2);
  localparam logic [SHIFT_W-1:0] c_k_max = {1'b0, {(SHIFT_W-1){1'b1}}};
  localparam logic [SHIFT_W-1:0] c_k_min = {1'b1, {(SHIFT_W-1){1'b0}}};

  logic [1:0]         r_state;
  logic [DATA_W-1:0]  r_x;
  logic [DATA_W-1:0]  r_x_out;
  logic               r_done;
  logic               r_err;
  logic [SHIFT_W-1:0] r_k;
  logic [DATA_W-1:0]  r_corr;

  logic [DATA_W-1:0]  w_x_next;
  logic [SHIFT_W-1:0] w_k_next;
  logic               w_done_next;
  logic               w_err_set;
  logic [DATA_W-1:0]  w_k_ext;
  logic [DATA_W-1:0]  w_corr;

  always_comb begin
    w_x_next    = r_x;
    w_k_next    = r_k;
    w_done_next = 1'b1;
    w_err_set   = 1'b0;
    if (r_x == '0) begin
      w_x_next  = '0;
      w_err_set = 1'b1;
    end else if (r_x >= c_hi) begin
      w_x_next    = r_x >> 1;
      w_done_next = 1'b0;
      // k saturates at the signed range limit and flags the overflow
      if (r_k == c_k_max) w_err_set = 1'b1;
      else                w_k_next  = r_k + SHIFT_W'(1);
    end else if (r_x < c_lo) begin
      w_x_next    = r_x << 1;
      w_done_next = 1'b0;
      if (r_k == c_k_min) w_err_set = 1'b1;
      else                w_k_next  = r_k - SHIFT_W'(1);
    end
  end

  // Low DATA_W bits of the product are the two's complement k*LN2
  assign w_k_ext = {{(DATA_W-SHIFT_W){w_k_next[SHIFT_W-1]}}, w_k_next};
  assign w_corr  = w_k_ext * c_ln2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_x_out <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_k     <= '0;
      r_corr  <= '0;
    end else if (clear_i) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_k     <= '0;
      r_corr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_x     <= x_i;
            r_state <= EVAL;
          end
        end
        EVAL: begin
          r_x_out <= w_x_next;
          r_k     <= w_k_next;
          r_done  <= w_done_next;
          r_corr  <= w_corr;
          if (w_err_set) r_err <= 1'b1;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign x_o         = r_x_out;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign busy_o      = (r_state != IDLE);
  assign shift_cnt_o = r_k;
  assign corr_o      = r_corr;

endmodule
`default_nettype wire
